// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch (read-only) and a load/store requester onto one shared memory port.
// Latency: mem_isRequest rises the cycle after a request is seen in IDLE; x_done pulses the cycle after mem_requestDone.
// Backpressure: requesters hold x_req until x_done; one transaction at a time, aborted after TIMEOUT busy cycles.
//
// Ports:
//   clk, rst_n                              clock, asynchronous active-low reset
//   f_req, f_addr                           fetch request and byte address
//   f_done, f_valid, f_err, f_dout          fetch completion pulse, read valid, timeout flag, read data
//   l_req, l_addr, l_din, l_we              load/store request, address, write data, byte enables (0 = read)
//   l_done, l_valid, l_err, l_dout          load/store completion pulse, read valid, timeout flag, read data
//   mem_isRequest, mem_addr, mem_din, mem_we    shared port request side (all registered)
//   mem_requestDone, mem_readValid, mem_dout    shared port response side
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_done,
    output logic        f_valid,
    output logic        f_err,
    output logic [31:0] f_dout,
    input  logic        l_req,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_din,
    input  logic [3:0]  l_we,
    output logic        l_done,
    output logic        l_valid,
    output logic        l_err,
    output logic [31:0] l_dout,
    output logic        mem_isRequest,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_we,
    input  logic        mem_requestDone,
    input  logic        mem_readValid,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_L = 2'd2
    } state_t;

    // The counter holds the number of completed no-response busy cycles, so
    // the last allowed busy cycle is the one where it reads TIMEOUT-1.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      stateNext;
    logic        lastGrant;     // 0: fetch was served last, 1: load/store
    logic [15:0] waitCnt;
    logic        grantF;
    logic        grantL;
    logic        finish;
    logic        abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        grantF    = 1'b0;
        grantL    = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                // With both requesting, fetch wins only if load/store went last.
                if (f_req && (!l_req || lastGrant)) begin
                    grantF    = 1'b1;
                    stateNext = BUSY_F;
                end else if (l_req) begin
                    grantL    = 1'b1;
                    stateNext = BUSY_L;
                end
            end
            BUSY_F, BUSY_L: begin
                // A response in the final allowed cycle still counts as success.
                if (mem_requestDone) begin
                    finish    = 1'b1;
                    stateNext = IDLE;
                end else if (waitCnt == LAST_WAIT) begin
                    abort     = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant     <= 1'b1;
            waitCnt       <= 16'd0;
            mem_isRequest <= 1'b0;
            mem_addr      <= 32'd0;
            mem_din       <= 32'd0;
            mem_we        <= 4'd0;
            f_done        <= 1'b0;
            f_valid       <= 1'b0;
            f_err         <= 1'b0;
            f_dout        <= 32'd0;
            l_done        <= 1'b0;
            l_valid       <= 1'b0;
            l_err         <= 1'b0;
            l_dout        <= 32'd0;
        end else begin
            f_done  <= 1'b0;
            f_valid <= 1'b0;
            f_err   <= 1'b0;
            l_done  <= 1'b0;
            l_valid <= 1'b0;
            l_err   <= 1'b0;
            if (grantF) begin
                mem_isRequest <= 1'b1;
                mem_addr      <= f_addr;
                mem_din       <= 32'd0;
                mem_we        <= 4'd0;
                waitCnt       <= 16'd0;
            end else if (grantL) begin
                mem_isRequest <= 1'b1;
                mem_addr      <= l_addr;
                mem_din       <= l_din;
                mem_we        <= l_we;
                waitCnt       <= 16'd0;
            end else if (finish || abort) begin
                // Address/data registers keep their last value; only the strobe drops.
                mem_isRequest <= 1'b0;
                lastGrant     <= (state == BUSY_L);
                if (state == BUSY_F) begin
                    f_done  <= 1'b1;
                    f_valid <= finish & mem_readValid;
                    f_err   <= abort;
                    if (finish) begin
                        f_dout <= mem_dout;
                    end
                end else begin
                    l_done  <= 1'b1;
                    l_valid <= finish & mem_readValid;
                    l_err   <= abort;
                    if (finish) begin
                        l_dout <= mem_dout;
                    end
                end
            end else if (state != IDLE) begin
                waitCnt <= waitCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT = 4).
// Directed vector table, hand-written timeout/reset sequences, then random traffic against a transaction model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        fReq;
    logic [31:0] fAddr;
    logic        fDone, fValid, fErr;
    logic [31:0] fDout;
    logic        lReq;
    logic [31:0] lAddr, lDin;
    logic [3:0]  lWe;
    logic        lDone, lValid, lErr;
    logic [31:0] lDout;
    logic        memIsRequest;
    logic [31:0] memAddr, memDin;
    logic [3:0]  memWe;
    logic        memDone, memValid;
    logic [31:0] memDout;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst_n           (rstN),
        .f_req           (fReq),
        .f_addr          (fAddr),
        .f_done          (fDone),
        .f_valid         (fValid),
        .f_err           (fErr),
        .f_dout          (fDout),
        .l_req           (lReq),
        .l_addr          (lAddr),
        .l_din           (lDin),
        .l_we            (lWe),
        .l_done          (lDone),
        .l_valid         (lValid),
        .l_err           (lErr),
        .l_dout          (lDout),
        .mem_isRequest   (memIsRequest),
        .mem_addr        (memAddr),
        .mem_din         (memDin),
        .mem_we          (memWe),
        .mem_requestDone (memDone),
        .mem_readValid   (memValid),
        .mem_dout        (memDout)
    );

    typedef struct packed {
        logic        fReq;
        logic [31:0] fAddr;
        logic        lReq;
        logic [31:0] lAddr;
        logic [31:0] lDin;
        logic [3:0]  lWe;
        logic        mDone;
        logic        mValid;
        logic [31:0] mDout;
    } stim_t;

    typedef struct packed {
        logic        isReq;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  we;
        logic [2:0]  fDVE;   // {done, valid, err}
        logic [31:0] fDout;
        logic [2:0]  lDVE;
        logic [31:0] lDout;
    } obs_t;

    typedef struct packed {
        stim_t s;
        obs_t  e;
    } vec_t;

    function automatic stim_t S(logic fr, logic [31:0] fa, logic lr, logic [31:0] la,
                                logic [31:0] ld, logic [3:0] lw, logic md, logic mv,
                                logic [31:0] mo);
        return {fr, fa, lr, la, ld, lw, md, mv, mo};
    endfunction

    function automatic obs_t O(logic ir, logic [31:0] a, logic [31:0] d, logic [3:0] w,
                               logic [2:0] fdve, logic [31:0] fo, logic [2:0] ldve,
                               logic [31:0] lo);
        return {ir, a, d, w, fdve, fo, ldve, lo};
    endfunction

    function automatic obs_t getObs();
        return {memIsRequest, memAddr, memDin, memWe, fDone, fValid, fErr, fDout,
                lDone, lValid, lErr, lDout};
    endfunction

    task automatic drive(input stim_t s);
        fReq     = s.fReq;
        fAddr    = s.fAddr;
        lReq     = s.lReq;
        lAddr    = s.lAddr;
        lDin     = s.lDin;
        lWe      = s.lWe;
        memDone  = s.mDone;
        memValid = s.mValid;
        memDout  = s.mDout;
    endtask

    task automatic checkObs(input string name, input obs_t act, input obs_t exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got req=%b addr=%h din=%h we=%h fDVE=%b fDout=%h lDVE=%b lDout=%h | want req=%b addr=%h din=%h we=%h fDVE=%b fDout=%h lDVE=%b lDout=%h",
                     name, act.isReq, act.addr, act.din, act.we, act.fDVE, act.fDout, act.lDVE, act.lDout,
                     exp.isReq, exp.addr, exp.din, exp.we, exp.fDVE, exp.fDout, exp.lDVE, exp.lDout);
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: who owns the port, how long it has waited,
    // and which requester was served most recently.
    int    mOwner;      // -1 none, 0 fetch, 1 load/store
    int    mWaited;     // busy cycles elapsed in the current transaction
    int    mLast;       // requester served last
    obs_t  mExp;        // outputs expected after the next rising edge

    task automatic modelStep(input stim_t s);
        obs_t nxt;
        int   pick;
        nxt      = mExp;
        nxt.fDVE = 3'b000;
        nxt.lDVE = 3'b000;
        if (mOwner < 0) begin
            pick = -1;
            if (s.fReq && s.lReq) pick = (mLast == 1) ? 0 : 1;
            else if (s.fReq)      pick = 0;
            else if (s.lReq)      pick = 1;
            if (pick == 0) begin
                nxt.isReq = 1'b1; nxt.addr = s.fAddr; nxt.din = '0; nxt.we = '0;
            end else if (pick == 1) begin
                nxt.isReq = 1'b1; nxt.addr = s.lAddr; nxt.din = s.lDin; nxt.we = s.lWe;
            end
            mOwner  = pick;
            mWaited = 0;
        end else begin
            mWaited++;
            if (s.mDone || mWaited == TMO) begin
                nxt.isReq = 1'b0;
                if (mOwner == 0) begin
                    nxt.fDVE = s.mDone ? {1'b1, s.mValid, 1'b0} : 3'b101;
                    if (s.mDone) nxt.fDout = s.mDout;
                end else begin
                    nxt.lDVE = s.mDone ? {1'b1, s.mValid, 1'b0} : 3'b101;
                    if (s.mDone) nxt.lDout = s.mDout;
                end
                mLast  = mOwner;
                mOwner = -1;
            end
        end
        mExp = nxt;
    endtask

    vec_t tbl [17];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t rs;
        int    n;

        // Fetch read, store with changing inputs, alternation, ignored response in IDLE.
        tbl[0]  = {S(1, 32'h100, 0, 0, 0, 0, 0, 0, 0), O(1, 32'h100, 0, 0, 3'b000, 0, 3'b000, 0)};
        tbl[1]  = {S(1, 32'h100, 0, 0, 0, 0, 0, 0, 0), O(1, 32'h100, 0, 0, 3'b000, 0, 3'b000, 0)};
        tbl[2]  = {S(1, 32'h100, 0, 0, 0, 0, 0, 0, 0), O(1, 32'h100, 0, 0, 3'b000, 0, 3'b000, 0)};
        tbl[3]  = {S(1, 32'h100, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF),
                   O(0, 32'h100, 0, 0, 3'b110, 32'hDEADBEEF, 3'b000, 0)};
        tbl[4]  = {S(0, 0, 0, 0, 0, 0, 0, 0, 0), O(0, 32'h100, 0, 0, 3'b000, 32'hDEADBEEF, 3'b000, 0)};
        tbl[5]  = {S(0, 0, 1, 32'h80000010, 32'h12345678, 4'b0011, 0, 0, 0),
                   O(1, 32'h80000010, 32'h12345678, 4'b0011, 3'b000, 32'hDEADBEEF, 3'b000, 0)};
        tbl[6]  = {S(0, 0, 1, 32'hFFFF0000, 32'hAAAAAAAA, 4'hF, 0, 0, 0),
                   O(1, 32'h80000010, 32'h12345678, 4'b0011, 3'b000, 32'hDEADBEEF, 3'b000, 0)};
        tbl[7]  = {S(0, 0, 1, 32'hFFFF0000, 32'hAAAAAAAA, 4'hF, 1, 0, 32'h5555),
                   O(0, 32'h80000010, 32'h12345678, 4'b0011, 3'b000, 32'hDEADBEEF, 3'b100, 32'h5555)};
        tbl[8]  = {S(0, 0, 0, 0, 0, 0, 0, 0, 0),
                   O(0, 32'h80000010, 32'h12345678, 4'b0011, 3'b000, 32'hDEADBEEF, 3'b000, 32'h5555)};
        tbl[9]  = {S(1, 32'h200, 1, 32'h300, 32'h1, 4'hF, 0, 0, 0),
                   O(1, 32'h200, 0, 0, 3'b000, 32'hDEADBEEF, 3'b000, 32'h5555)};
        tbl[10] = {S(1, 32'h200, 1, 32'h300, 32'h1, 4'hF, 1, 1, 32'h11111111),
                   O(0, 32'h200, 0, 0, 3'b110, 32'h11111111, 3'b000, 32'h5555)};
        tbl[11] = {S(1, 32'h200, 1, 32'h300, 32'h1, 4'hF, 0, 0, 0),
                   O(1, 32'h300, 32'h1, 4'hF, 3'b000, 32'h11111111, 3'b000, 32'h5555)};
        tbl[12] = {S(1, 32'h200, 1, 32'h300, 32'h1, 4'hF, 1, 1, 32'h22222222),
                   O(0, 32'h300, 32'h1, 4'hF, 3'b000, 32'h11111111, 3'b110, 32'h22222222)};
        tbl[13] = {S(1, 32'h200, 1, 32'h300, 32'h1, 4'hF, 0, 0, 0),
                   O(1, 32'h200, 0, 0, 3'b000, 32'h11111111, 3'b000, 32'h22222222)};
        tbl[14] = {S(1, 32'h200, 1, 32'h300, 32'h1, 4'hF, 1, 0, 32'h33333333),
                   O(0, 32'h200, 0, 0, 3'b100, 32'h33333333, 3'b000, 32'h22222222)};
        tbl[15] = {S(0, 0, 0, 0, 0, 0, 1, 1, 32'h99),
                   O(0, 32'h200, 0, 0, 3'b000, 32'h33333333, 3'b000, 32'h22222222)};
        tbl[16] = {S(0, 0, 0, 0, 0, 0, 0, 0, 0),
                   O(0, 32'h200, 0, 0, 3'b000, 32'h33333333, 3'b000, 32'h22222222)};

        rstN = 1'b0;
        drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        checkObs("reset_state", getObs(), '0);
        rstN = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].s);
            @(negedge clk);
            checkObs($sformatf("vec%0d", i), getObs(), tbl[i].e);
        end

        // Memory never answers: exactly TMO busy cycles, then an error completion.
        drive(S(0, 0, 1, 32'h40, 32'h0, 4'h0, 0, 0, 0));
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!memIsRequest) break;
            n++;
        end
        checkVal("timeout_busy_cycles", 32'(n), 32'(TMO));
        checkVal("timeout_done_flags", {29'd0, lDone, lValid, lErr}, 32'b101);
        checkVal("timeout_dout_hold", lDout, 32'h22222222);
        drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkVal("timeout_single_pulse", {30'd0, lDone, lErr}, 32'd0);

        // Next load completes normally.
        drive(S(0, 0, 1, 32'h44, 32'h0, 4'h0, 0, 0, 0));
        @(negedge clk);
        checkVal("retry_busy", {31'd0, memIsRequest}, 32'd1);
        drive(S(0, 0, 1, 32'h44, 32'h0, 4'h0, 1, 1, 32'hC0FFEE00));
        @(negedge clk);
        checkVal("retry_flags", {29'd0, lDone, lValid, lErr}, 32'b110);
        checkVal("retry_dout", lDout, 32'hC0FFEE00);
        drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);

        // Response in the last allowed busy cycle is a normal completion.
        drive(S(0, 0, 1, 32'h48, 32'h0, 4'h0, 0, 0, 0));
        repeat (TMO) @(negedge clk);
        checkVal("boundary_still_busy", {31'd0, memIsRequest}, 32'd1);
        drive(S(0, 0, 1, 32'h48, 32'h0, 4'h0, 1, 1, 32'h0BADF00D));
        @(negedge clk);
        checkVal("boundary_flags", {29'd0, lDone, lValid, lErr}, 32'b110);
        drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);

        // Serve a fetch so fetch is "last granted", then reset in the middle of another fetch.
        drive(S(1, 32'h500, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(S(1, 32'h500, 0, 0, 0, 0, 1, 1, 32'h1));
        @(negedge clk);
        checkVal("pre_reset_fetch_done", {31'd0, fDone}, 32'd1);
        drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(S(1, 32'h600, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkVal("busy_before_reset", memAddr, 32'h600);
        #1 rstN = 1'b0;
        #1 checkObs("reset_mid_busy", getObs(), '0);
        drive(S(1, 32'h600, 1, 32'h700, 32'h7, 4'h1, 0, 0, 0));
        @(negedge clk);
        checkVal("no_done_in_reset", {29'd0, fDone, fValid, fErr}, 32'd0);
        rstN = 1'b1;
        @(negedge clk);
        checkObs("fetch_first_after_reset", getObs(), O(1, 32'h600, 0, 0, 3'b000, 0, 3'b000, 0));
        drive(S(0, 0, 1, 32'h700, 32'h7, 4'h1, 1, 1, 32'h66));
        @(negedge clk);
        checkVal("post_reset_fetch_done", {29'd0, fDone, fValid, fErr}, 32'b110);

        // Random traffic against the transaction model.
        drive(S(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rstN = 1'b0;
        @(negedge clk);
        rstN    = 1'b1;
        mOwner  = -1;
        mWaited = 0;
        mLast   = 1;
        mExp    = '0;
        for (int c = 0; c < 2000; c++) begin
            checkObs($sformatf("rand%0d", c), getObs(), mExp);
            rs.fReq   = ($urandom_range(0, 9) < 6);
            rs.fAddr  = $urandom;
            rs.lReq   = ($urandom_range(0, 9) < 6);
            rs.lAddr  = $urandom;
            rs.lDin   = $urandom;
            rs.lWe    = 4'($urandom);
            rs.mDone  = ($urandom_range(0, 9) < 3);
            rs.mValid = 1'($urandom);
            rs.mDout  = $urandom;
            drive(rs);
            modelStep(rs);
            @(negedge clk);
        end
        checkObs("rand_final", getObs(), mExp);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
